instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 16 +
 rtl/instruction_fetch_unit_fetch_buffer.sv | 100 ++++++++++
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, counter type and credit helper for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [2:0]  FETCH_BUF_DEPTH = 3'd2;

  typedef logic [1:0] cnt_t;

  // Room for one more request once this cycle's pop is taken into account.
  function automatic logic credit_ok(input cnt_t occ, input cnt_t outstanding, input logic pop);
    logic [2:0] used;
    used = {1'b0, occ} + {1'b0, outstanding};
    return (used < (FETCH_BUF_DEPTH + {2'b00, pop}));
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry FIFO of {PC, word}. Entry 0 is the head and reads back as NOP/0 when empty,
// so the head outputs come straight from registers.
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic [31:0]         push_word,
  input  logic                pop,
  input  logic                flush,
  output cnt_t                occ,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic [31:0]         head_word
);

  logic [PC_WIDTH-1:0] head_pc_r, tail_pc_r, head_pc_n_s, tail_pc_n_s;
  logic [31:0]         head_word_r, tail_word_r, head_word_n_s, tail_word_n_s;
  cnt_t                occ_r, occ_n_s;

  // Next-state for head/tail entries and occupancy; flush wins over push and pop.
  always_comb begin
    head_pc_n_s   = head_pc_r;
    head_word_n_s = head_word_r;
    tail_pc_n_s   = tail_pc_r;
    tail_word_n_s = tail_word_r;
    occ_n_s       = occ_r;
    if (flush) begin
      occ_n_s       = 2'd0;
      head_pc_n_s   = {PC_WIDTH{1'b0}};
      head_word_n_s = NOP_INSTR;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_pc_n_s   = push_pc;
            head_word_n_s = push_word;
            occ_n_s       = 2'd1;
          end else if (occ_r == 2'd1) begin
            tail_pc_n_s   = push_pc;
            tail_word_n_s = push_word;
            occ_n_s       = 2'd2;
          end else begin
            occ_n_s = occ_r;
          end
        end
        2'b01: begin
          if (occ_r == 2'd2) begin
            head_pc_n_s   = tail_pc_r;
            head_word_n_s = tail_word_r;
            occ_n_s       = 2'd1;
          end else begin
            head_pc_n_s   = {PC_WIDTH{1'b0}};
            head_word_n_s = NOP_INSTR;
            occ_n_s       = 2'd0;
          end
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ_r == 2'd2) begin
            head_pc_n_s   = tail_pc_r;
            head_word_n_s = tail_word_r;
            tail_pc_n_s   = push_pc;
            tail_word_n_s = push_word;
          end else begin
            head_pc_n_s   = push_pc;
            head_word_n_s = push_word;
            occ_n_s       = 2'd1;
          end
        end
        default: occ_n_s = occ_r;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc_r   <= {PC_WIDTH{1'b0}};
      head_word_r <= NOP_INSTR;
      tail_pc_r   <= {PC_WIDTH{1'b0}};
      tail_word_r <= 32'h0000_0000;
      occ_r       <= 2'd0;
    end else begin
      head_pc_r   <= head_pc_n_s;
      head_word_r <= head_word_n_s;
      tail_pc_r   <= tail_pc_n_s;
      tail_word_r <= tail_word_n_s;
      occ_r       <= occ_n_s;
    end
  end

  assign occ       = occ_r;
  assign head_pc   = head_pc_r;
  assign head_word = head_word_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, credit-limited PMEM requests, stale-response discard on redirect,
// and a 2-entry buffer presenting words to the decoder.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                pmem_req,
  output logic [PC_WIDTH-1:0] pmem_addr,
  input  logic                pmem_ready,
  input  logic                pmem_rvalid,
  input  logic [31:0]         pmem_rdata,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc
);

  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(32'd4);
  localparam logic [PC_WIDTH-1:0] PC_RESET = {RESET_VECTOR[PC_WIDTH-1:2], 2'b00};

  logic [PC_WIDTH-1:0] pc_r, pc_n_s;
  cnt_t                outstanding_r, outstanding_n_s;
  cnt_t                discard_r, discard_n_s;
  cnt_t                occ_s;
  logic [PC_WIDTH-1:0] rq_pc_r [2];
  logic                rq_wr_r, rq_rd_r;
  logic                pop_s, accept_s, rsp_s, push_s;
  logic                unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  assign instr_valid = (occ_s != 2'd0);
  assign pop_s       = instr_valid && instr_ready;
  // Held low while in reset so no request escapes before release.
  assign pmem_req    = rst_n && !redirect_valid && credit_ok(occ_s, outstanding_r, pop_s);
  assign pmem_addr   = pc_r;
  assign accept_s    = pmem_req && pmem_ready;
  assign rsp_s       = pmem_rvalid && (outstanding_r != 2'd0);
  assign push_s      = rsp_s && (discard_r == 2'd0) && !redirect_valid;

  // Next PC, in-flight count and discard count; redirect overrides everything.
  always_comb begin
    pc_n_s          = pc_r;
    outstanding_n_s = outstanding_r;
    discard_n_s     = discard_r;
    case ({accept_s, rsp_s})
      2'b10:   outstanding_n_s = outstanding_r + 2'd1;
      2'b01:   outstanding_n_s = outstanding_r - 2'd1;
      default: outstanding_n_s = outstanding_r;
    endcase
    if (redirect_valid) begin
      pc_n_s      = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      discard_n_s = outstanding_n_s;
    end else begin
      if (accept_s) begin
        pc_n_s = pc_r + PC_STEP;
      end else begin
        pc_n_s = pc_r;
      end
      if (rsp_s && (discard_r != 2'd0)) begin
        discard_n_s = discard_r - 2'd1;
      end else begin
        discard_n_s = discard_r;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= PC_RESET;
      outstanding_r <= 2'd0;
      discard_r     <= 2'd0;
    end else begin
      pc_r          <= pc_n_s;
      outstanding_r <= outstanding_n_s;
      discard_r     <= discard_n_s;
    end
  end

  // Request-PC queue; stale entries retire alongside their discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_pc_r[0] <= {PC_WIDTH{1'b0}};
      rq_pc_r[1] <= {PC_WIDTH{1'b0}};
      rq_wr_r    <= 1'b0;
      rq_rd_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        rq_pc_r[rq_wr_r] <= pc_r;
        rq_wr_r          <= ~rq_wr_r;
      end
      if (rsp_s) begin
        rq_rd_r <= ~rq_rd_r;
      end
    end
  end

  fetch_buffer #(
    .PC_WIDTH (PC_WIDTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_pc   (rq_pc_r[rq_rd_r]),
    .push_word (pmem_rdata),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .occ       (occ_s),
    .head_pc   (instr_pc),
    .head_word (instr)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: a PMEM model with random in-order latency, and an expected
// instruction stream (consecutive PCs from the last restart point) checked at each pop.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        pmem_req;
  logic [31:0] pmem_addr;
  logic        pmem_ready;
  logic        pmem_rvalid;
  logic [31:0] pmem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instruction_fetch_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pmem_req       (pmem_req),
    .pmem_addr      (pmem_addr),
    .pmem_ready     (pmem_ready),
    .pmem_rvalid    (pmem_rvalid),
    .pmem_rdata     (pmem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

  rsp_t        resp_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_next_pc;
  int          cyc, last_due, lat_min, lat_max;
  int          n_vec, n_err, pops;
  logic        mon_en;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h5A3C_9000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = exp_next_pc;
      e.word = mem_word(exp_next_pc);
      exp_q.push_back(e);
      exp_next_pc = exp_next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next_pc = {pc[31:2], 2'b00};
    top_up();
  endtask

  // One clock cycle: drive at negedge, sample just after, apply model at posedge.
  task automatic step(input logic ir, input logic rv, input logic [31:0] rpc, input logic pr);
    rsp_t r;
    int   d;
    @(negedge clk);
    instr_ready    = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pmem_ready     = pr;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      r           = resp_q.pop_front();
      pmem_rvalid = 1'b1;
      pmem_rdata  = r.data;
    end else begin
      pmem_rvalid = 1'b0;
      pmem_rdata  = $urandom;
    end
    #1;
    s_req   = pmem_req;
    s_addr  = pmem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_instr = instr;
    if (pmem_req) check("addr_align", {30'd0, pmem_addr[1:0]}, 32'd0);
    if (rv) check("req_during_redirect", {31'd0, pmem_req}, 32'd0);
    if (pmem_req && pmem_ready) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      r.data   = mem_word(pmem_addr);
      r.due    = d;
      resp_q.push_back(r);
    end
    @(posedge clk);
    cyc++;
    if (rv) restart(rpc);
    else top_up();
  endtask

  // Monitor: every pop must match the next expected {pc, word}; empty shows NOP.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      if (!instr_valid) begin
        check("nop_when_empty", instr, NOP);
      end else if (instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL exp_underflow: pop with pc %h but nothing expected", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr_word", instr, e.word);
          pops++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, pmem_req}, 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int   held_pc, held_instr, p0;
    logic seen;
    n_vec = 0; n_err = 0; pops = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1; mon_en = 1'b0;
    rst_n = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    pmem_ready = 1'b0; pmem_rvalid = 1'b0; pmem_rdata = 32'd0;
    s_req = 1'b0; s_valid = 1'b0; s_addr = 32'd0; s_pc = 32'd0; s_instr = 32'd0;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    restart(32'h0000_0000);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill: requests 0,4,8 back to back, first word on cycle 3, no bubbles.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("fill_req1", {31'd0, s_req}, 32'd1);
    check("fill_addr1", s_addr, 32'h0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("fill_addr2", s_addr, 32'h4);
    check("fill_valid2", {31'd0, s_valid}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("fill_addr3", s_addr, 32'h8);
    check("fill_pc3", s_pc, 32'h0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("fill_pc4", s_pc, 32'h4);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("fill_pc5", s_pc, 32'h8);

    // Decoder stall for 5 cycles: requests stop, head word held.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    held_pc    = s_pc;
    held_instr = s_instr;
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
    check("stall_req", {31'd0, s_req}, 32'd0);
    check("stall_valid", {31'd0, s_valid}, 32'd1);
    check("stall_pc", s_pc, held_pc);
    check("stall_instr", s_instr, held_instr);
    repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Redirect coinciding with a response and a pop (1-cycle PMEM steady state).
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_valid_t1", {31'd0, s_valid}, 32'd0);
    check("redir_instr_t1", s_instr, NOP);
    check("redir_req_t1", {31'd0, s_req}, 32'd1);
    check("redir_addr_t1", s_addr, 32'h200);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_instr_t2", s_instr, NOP);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_valid_t3", {31'd0, s_valid}, 32'd1);
    check("redir_pc_t3", s_pc, 32'h200);

    // PC wrap at the top of the address space; low redirect bits ignored.
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_addr2", s_addr, 32'h0000_0000);
    repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);

    // 3-cycle PMEM: redirect to 0x103 while two requests are in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && resp_q.size() < 2; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("two_in_flight", resp_q.size(), 32'd2);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1);
      if (s_valid) begin
        seen = 1'b1;
        check("redir103_first_pc", s_pc, 32'h100);
      end
    end
    check("redir103_arrived", {31'd0, seen}, 32'd1);
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Async reset between edges with the buffer full, then a stray response.
    lat_min = 1; lat_max = 1;
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    instr_ready = 1'b0; redirect_valid = 1'b0; pmem_ready = 1'b0; pmem_rvalid = 1'b0;
    resp_q.delete();
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    last_due = cyc;
    begin
      rsp_t stray;
      stray.data = 32'hDEAD_BEEF;
      stray.due  = cyc;
      resp_q.push_back(stray);
    end
    restart(32'h0000_0000);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("post_reset_addr", s_addr, 32'h0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("post_reset_stray_ignored", {31'd0, s_valid}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("post_reset_pc", s_pc, 32'h0);

    // Randomized traffic: stalls, PMEM back-pressure, latency 1..4, redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom,
           $urandom_range(0, 3) != 0);
    end

    // Drain with an ideal PMEM: the stream must keep flowing.
    lat_min = 1; lat_max = 1;
    repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);
    p0 = pops;
    repeat (20) step(1'b1, 1'b0, 32'd0, 1'b1);
    check("drain_progress", {31'd0, (pops - p0) >= 18}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
